// File: rtl/cliff_round_ctrl.sv
// Round sequencer for the cliff game: idle nudging, timed running steps, lose blink.
// Replaces derived game/debounce clocks with a single clock and registered strobes.
module cliff_round_ctrl #(
  parameter int unsigned DIV_SLOW  = 50000000,
  parameter int unsigned DIV_MED   = 12500000,
  parameter int unsigned DIV_FAST  = 5000000,
  parameter int unsigned FLASH_DIV = 5000000,
  parameter int unsigned SCORE_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_p,
  input  logic               up_p,
  input  logic               down_p,
  input  logic               left_p,
  input  logic               right_p,
  input  logic [7:0]         pos,
  input  logic [2:0]         lmargin,
  input  logic [2:0]         rmargin,
  output logic [1:0]         state,
  output logic [1:0]         speed,
  output logic [1:0]         dir,
  output logic               step_en,
  output logic               step_dir,
  output logic               load_start,
  output logic               clear_people,
  output logic               flash,
  output logic [SCORE_W-1:0] score
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_LOSE = 2'b10
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           speed_q, speed_d, speed_nx;
  logic [1:0]           dir_q, dir_d;
  logic                 step_q, step_d;
  logic                 sdir_q, sdir_d;
  logic                 load_q, load_d;
  logic                 clear_q, clear_d;
  logic                 flash_q, flash_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [31:0]          tick_q, tick_d;
  logic [31:0]          fcnt_q, fcnt_d;
  logic [31:0]          div_sel;
  logic [7:0]           rthresh;
  logic                 lose_cond;
  logic                 tick_term;
  logic                 flash_term;
  logic                 speed_chg;
  logic                 strobe_q;

  // Margins are widened before subtracting so the threshold never wraps.
  assign rthresh   = 8'd15 - {5'b00000, rmargin};
  assign lose_cond = (pos >= rthresh) || (pos <= {5'b00000, lmargin});

  always_comb begin
    div_sel = DIV_SLOW;
    case (speed_q)
      2'd1:    div_sel = DIV_MED;
      2'd2:    div_sel = DIV_FAST;
      default: div_sel = DIV_SLOW;
    endcase
  end

  assign tick_term  = (tick_q == div_sel - 32'd1);
  assign flash_term = (fcnt_q == FLASH_DIV - 32'd1);
  assign strobe_q   = step_q | load_q | clear_q;

  always_comb begin
    speed_nx = speed_q;
    if (up_p) begin
      if (speed_q != 2'd2) speed_nx = speed_q + 2'd1;
    end else if (down_p) begin
      if (speed_q != 2'd0) speed_nx = speed_q - 2'd1;
    end
  end

  assign speed_chg = (speed_nx != speed_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      speed_q <= '0;
      dir_q   <= '0;
      step_q  <= 1'b0;
      sdir_q  <= 1'b0;
      load_q  <= 1'b0;
      clear_q <= 1'b0;
      flash_q <= 1'b0;
      score_q <= '0;
      tick_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      speed_q <= speed_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      sdir_q  <= sdir_d;
      load_q  <= load_d;
      clear_q <= clear_d;
      flash_q <= flash_d;
      score_q <= score_d;
      tick_q  <= tick_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_p) state_d = S_RUN;
      S_RUN: begin
        if (start_p)        state_d = S_IDLE;
        else if (lose_cond) state_d = S_LOSE;
      end
      S_LOSE: if (start_p) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    speed_d = speed_nx;
    dir_d   = dir_q;
    step_d  = 1'b0;
    sdir_d  = sdir_q;
    load_d  = 1'b0;
    clear_d = 1'b0;
    flash_d = flash_q;
    score_d = score_q;
    tick_d  = '0;
    fcnt_d  = '0;
    case (state_q)
      S_IDLE: begin
        dir_d = '0;
        // A strobe in the previous cycle blocks a step so strobes never run back-to-back.
        if (start_p) begin
          score_d = '0;
        end else if (left_p) begin
          if ((pos < 8'd14) && !strobe_q) begin
            step_d = 1'b1;
            sdir_d = 1'b1;
          end
        end else if (right_p && (pos > 8'd1) && !strobe_q) begin
          step_d = 1'b1;
          sdir_d = 1'b0;
        end
      end
      S_RUN: begin
        if (start_p) begin
          load_d  = 1'b1;
          speed_d = '0;
          dir_d   = '0;
        end else if (lose_cond) begin
          clear_d = 1'b1;
          dir_d   = '0;
          flash_d = 1'b0;
        end else begin
          if (left_p)       dir_d = 2'b01;
          else if (right_p) dir_d = 2'b10;
          if (!speed_chg && !tick_term) tick_d = tick_q + 32'd1;
          if (tick_term && (dir_q != 2'b00) && !strobe_q) begin
            step_d = 1'b1;
            sdir_d = (dir_q == 2'b01);
            if (score_q != '1) score_d = score_q + SCORE_W'(1);
          end
        end
      end
      S_LOSE: begin
        if (start_p) begin
          load_d  = 1'b1;
          speed_d = '0;
          flash_d = 1'b0;
          score_d = '0;
        end else if (flash_term) begin
          flash_d = ~flash_q;
        end else begin
          fcnt_d = fcnt_q + 32'd1;
        end
      end
      default: ;
    endcase
  end

  assign state        = state_q;
  assign speed        = speed_q;
  assign dir          = dir_q;
  assign step_en      = step_q;
  assign step_dir     = sdir_q;
  assign load_start   = load_q;
  assign clear_people = clear_q;
  assign flash        = flash_q;
  assign score        = score_q;

endmodule

// File: tb/tb_cliff_round_ctrl.sv
// Directed round scenarios plus randomized pulses, checked every cycle against a rule-level model.
module tb_cliff_round_ctrl;

  localparam int SW = 16;
  localparam int FL = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start_p = 1'b0, up_p = 1'b0, down_p = 1'b0, left_p = 1'b0, right_p = 1'b0;
  logic [7:0]    pos_r;
  logic [2:0]    lm_r = 3'd0, rm_r = 3'd0;
  logic [1:0]    state, speed, dir;
  logic          step_en, step_dir, load_start, clear_people, flash;
  logic [SW-1:0] score;

  int checks = 0;
  int failures = 0;

  int period_tab [3] = '{8, 4, 2};

  int m_state, m_speed, m_dir, m_score, m_tick, m_fcnt, m_pos;
  bit m_step, m_sdir, m_load, m_clear, m_flash;

  cliff_round_ctrl #(
    .DIV_SLOW(8), .DIV_MED(4), .DIV_FAST(2), .FLASH_DIV(FL), .SCORE_W(SW)
  ) dut (
    .clk(clk), .reset(reset), .start_p(start_p), .up_p(up_p), .down_p(down_p),
    .left_p(left_p), .right_p(right_p), .pos(pos_r), .lmargin(lm_r), .rmargin(rm_r),
    .state(state), .speed(speed), .dir(dir), .step_en(step_en), .step_dir(step_dir),
    .load_start(load_start), .clear_people(clear_people), .flash(flash), .score(score)
  );

  always #5 clk = ~clk;

  // Datapath stub: pos moves on the cycle after each strobe.
  always @(posedge clk) begin
    if (reset)             pos_r <= 8'd7;
    else if (step_en)      pos_r <= step_dir ? pos_r + 8'd1 : pos_r - 8'd1;
    else if (load_start)   pos_r <= 8'd7;
    else if (clear_people) pos_r <= 8'd0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_speed = 0; m_dir = 0; m_score = 0; m_tick = 0; m_fcnt = 0; m_pos = 7;
    m_step = 0; m_sdir = 0; m_load = 0; m_clear = 0; m_flash = 0;
  endtask

  task automatic model_clock(input bit st, input bit up, input bit dn, input bit lf, input bit rt);
    int  n_pos, new_speed;
    bit  lose, prev, term;
    n_pos = m_pos;
    if (m_step)       n_pos = m_sdir ? m_pos + 1 : m_pos - 1;
    else if (m_load)  n_pos = 7;
    else if (m_clear) n_pos = 0;
    n_pos = n_pos & 255;

    lose = (m_pos >= 15 - int'(rm_r)) || (m_pos <= int'(lm_r));
    prev = m_step || m_load || m_clear;
    term = (m_tick == period_tab[m_speed] - 1);
    new_speed = m_speed;
    if (up)      new_speed = (m_speed < 2) ? m_speed + 1 : 2;
    else if (dn) new_speed = (m_speed > 0) ? m_speed - 1 : 0;

    m_step = 0; m_load = 0; m_clear = 0;
    if (m_state == 0) begin
      m_tick = 0; m_fcnt = 0;
      if (st) begin
        m_state = 1; m_dir = 0; m_score = 0;
      end else if (lf) begin
        if (m_pos < 14 && !prev) begin m_step = 1; m_sdir = 1; end
      end else if (rt && m_pos > 1 && !prev) begin
        m_step = 1; m_sdir = 0;
      end
    end else if (m_state == 1) begin
      m_fcnt = 0;
      if (st) begin
        m_state = 0; m_load = 1; new_speed = 0; m_dir = 0; m_tick = 0;
      end else if (lose) begin
        m_state = 2; m_clear = 1; m_dir = 0; m_tick = 0; m_flash = 0;
      end else begin
        if (term && m_dir != 0 && !prev) begin
          m_step = 1; m_sdir = (m_dir == 1);
          if (m_score < (1 << SW) - 1) m_score++;
        end
        m_tick = (new_speed != m_speed || term) ? 0 : m_tick + 1;
        if (lf)      m_dir = 1;
        else if (rt) m_dir = 2;
      end
    end else begin
      m_tick = 0;
      if (st) begin
        m_state = 0; m_load = 1; new_speed = 0; m_flash = 0; m_score = 0; m_fcnt = 0;
      end else if (m_fcnt == FL - 1) begin
        m_fcnt = 0; m_flash = !m_flash;
      end else begin
        m_fcnt++;
      end
    end
    m_speed = new_speed;
    m_pos = n_pos;
  endtask

  task automatic check_all();
    check("state", 32'(state), 32'(m_state));
    check("speed", 32'(speed), 32'(m_speed));
    check("dir", 32'(dir), 32'(m_dir));
    check("step_en", 32'(step_en), 32'(m_step));
    if (m_step) check("step_dir", 32'(step_dir), 32'(m_sdir));
    check("load_start", 32'(load_start), 32'(m_load));
    check("clear_people", 32'(clear_people), 32'(m_clear));
    check("flash", 32'(flash), 32'(m_flash));
    check("score", 32'(score), 32'(m_score));
    check("pos", 32'(pos_r), 32'(m_pos));
  endtask

  task automatic cycle(input bit st, input bit up, input bit dn, input bit lf, input bit rt);
    @(negedge clk);
    reset = 1'b0;
    start_p = st; up_p = up; down_p = dn; left_p = lf; right_p = rt;
    model_clock(st, up, dn, lf, rt);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic reset_cycle();
    @(negedge clk);
    reset = 1'b1;
    start_p = 0; up_p = 0; down_p = 0; left_p = 0; right_p = 0;
    model_reset();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic measure_period(output int p);
    int first;
    first = -1;
    p = -1;
    for (int i = 0; i < 64; i++) begin
      cycle(0, 0, 0, 0, 0);
      if (step_en) begin
        if (first < 0) first = i;
        else begin p = i - first; break; end
      end
    end
  endtask

  initial begin
    int nsteps, nclear, toggles, p;
    bit prev_flash;

    model_reset();
    reset_cycle();
    reset_cycle();
    check("reset_tick_state", 32'(state), 32'd0);

    // Idle nudging
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 1, 0);
      check("idle_step_dir", 32'(step_dir), 32'd1);
      cycle(0, 0, 0, 0, 0);
    end
    check("idle_pos10", 32'(pos_r), 32'd10);
    check("idle_score0", 32'(score), 32'd0);

    // Run at speed 0 until the crowd walks off the right cliff
    cycle(1, 0, 0, 0, 0);
    check("run_entered", 32'(state), 32'd1);
    cycle(0, 0, 0, 1, 0);
    nsteps = 0; nclear = 0;
    for (int i = 0; i < 200; i++) begin
      cycle(0, 0, 0, 0, 0);
      if (step_en) nsteps++;
      if (clear_people) nclear++;
      if (state == 2'd2) break;
    end
    check("lose_reached", 32'(state), 32'd2);
    check("run_steps", 32'(nsteps), 32'd5);
    check("run_score", 32'(score), 32'd5);
    check("clear_pulses", 32'(nclear), 32'd1);

    // Lose blink
    toggles = 0; nsteps = 0; prev_flash = flash;
    for (int i = 0; i < 12; i++) begin
      cycle(0, 0, 0, 0, 0);
      if (flash != prev_flash) toggles++;
      if (step_en) nsteps++;
      prev_flash = flash;
    end
    check("flash_toggles", 32'(toggles), 32'd4);
    check("lose_no_step", 32'(nsteps), 32'd0);
    cycle(1, 0, 0, 0, 0);
    check("restart_idle", 32'(state), 32'd0);
    check("restart_load", 32'(load_start), 32'd1);
    check("restart_score", 32'(score), 32'd0);
    cycle(0, 0, 0, 0, 0);
    check("reload_pos", 32'(pos_r), 32'd7);

    // Speed stepping
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 1, 0, 0, 0);
    check("speed_up1", 32'(speed), 32'd1);
    measure_period(p);
    check("period_med", 32'(p), 32'd4);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 1, 0, 0, 0);
    check("speed_up2", 32'(speed), 32'd2);
    measure_period(p);
    check("period_fast", 32'(p), 32'd2);
    cycle(0, 1, 0, 0, 0);
    check("speed_sat2", 32'(speed), 32'd2);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0);
    check("speed_down0", 32'(speed), 32'd0);
    measure_period(p);
    check("period_slow", 32'(p), 32'd8);

    // Restart wins over a simultaneous lose condition
    lm_r = 3'd7;
    cycle(1, 0, 0, 0, 0);
    check("prio_state", 32'(state), 32'd0);
    check("prio_load", 32'(load_start), 32'd1);
    check("prio_noclear", 32'(clear_people), 32'd0);
    lm_r = 3'd0;
    cycle(0, 0, 0, 0, 0);

    // Reset in the middle of a fast round
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0);
    reset_cycle();
    check("rst_state", 32'(state), 32'd0);
    check("rst_speed", 32'(speed), 32'd0);
    check("rst_dir", 32'(dir), 32'd0);
    check("rst_score", 32'(score), 32'd0);
    check("rst_nostep", 32'(step_en), 32'd0);

    // Randomized pulses with shifting margins
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) begin
        lm_r = 3'($urandom_range(0, 3));
        rm_r = 3'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 999) < 2) reset_cycle();
      else cycle($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 4,
                 $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 8,
                 $urandom_range(0, 99) < 8);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
